mult_arbiter: RTL and testbench

Shares one signed 8-bit `multiplier` between two requesters (e.g. the ALU-side MUL instruction path and the address/index unit) with round-robin arbitration. Each requester has a valid/ready operand channel and a valid/ready response channel. The block registers the granted operands, drives them onto the shared multiplier, and waits a fixed `MULT_LAT` cycles. It then captures the 16-bit product and returns it to the requester that issued it. One operation is in flight at a time.

---
 rtl/mult_arbiter.sv | 137 +++++++++++++
 tb/tb_mult_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one signed multiplier between two requesters
//
// Purpose: two requesters compete for a single shared multiplier. The granted
// operands are registered and held on mul_in1/mul_in2 for MULT_LAT cycles, then
// mul_out is captured and returned on the owner's response channel. One
// operation is in flight at a time.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req{0,1}_valid/ready      operand channel handshake per requester
//   req{0,1}_a, req{0,1}_b    signed operands per requester
//   rsp{0,1}_valid/ready      response channel handshake per requester
//   rsp{0,1}_data             product for the owner, 0 otherwise
//   mul_in1, mul_in2          operands driven to the shared multiplier
//   mul_out                   product returned by the shared multiplier
//   busy                      high whenever an operation is in progress

module mult_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MULT_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic [2*DATA_WIDTH-1:0] rsp0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [2*DATA_WIDTH-1:0] rsp1_data,
  output logic [DATA_WIDTH-1:0]   mul_in1,
  output logic [DATA_WIDTH-1:0]   mul_in2,
  input  logic [2*DATA_WIDTH-1:0] mul_out,
  output logic                    busy
);

  localparam int CW = $clog2(MULT_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last;
  logic                    r_owner;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_op_a;
  logic [DATA_WIDTH-1:0]   r_op_b;
  logic [2*DATA_WIDTH-1:0] r_result;

  logic w_idle;
  logic w_grant;
  logic w_accept;
  logic w_rsp_fire;

  assign w_idle = (r_state == S_IDLE);

  // On a tie the requester that was not served last wins; r_last resets to 1
  // so requester 0 takes the first tie.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Readies are gated by rst so they drop immediately with the asynchronous reset.
  assign req0_ready = rst & w_idle & req0_valid & ~w_grant;
  assign req1_ready = rst & w_idle & req1_valid &  w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign w_rsp_fire = (r_state == S_RESP) & (r_owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == CW'(1)) w_next = S_RESP;
      S_RESP:  if (w_rsp_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_grant ? req1_a : req0_a;
        r_op_b  <= w_grant ? req1_b : req0_b;
        r_owner <= w_grant;
        r_last  <= w_grant;
        r_cnt   <= CW'(MULT_LAT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
        // Count 1 marks the last cycle of the multiplier latency window.
        if (r_cnt == CW'(1)) begin
          r_result <= mul_out;
        end
      end
    end
  end

  assign mul_in1    = r_op_a;
  assign mul_in2    = r_op_b;
  assign busy       = ~w_idle;
  assign rsp0_valid = (r_state == S_RESP) & ~r_owner;
  assign rsp1_valid = (r_state == S_RESP) &  r_owner;
  assign rsp0_data  = rsp0_valid ? r_result : '0;
  assign rsp1_data  = rsp1_valid ? r_result : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - testbench for mult_arbiter at MULT_LAT=1 and MULT_LAT=3

module tb_mult_arbiter;

  logic        clk;
  logic        rst;
  logic        rq_v [2][2];
  logic        rq_r [2][2];
  logic [7:0]  rq_a [2][2];
  logic [7:0]  rq_b [2][2];
  logic        rs_v [2][2];
  logic        rs_r [2][2];
  logic [15:0] rs_d [2][2];
  logic [7:0]  mi1 [2];
  logic [7:0]  mi2 [2];
  logic        bsy [2];
  logic [15:0] mo0;
  logic [15:0] mo1;
  logic [15:0] p1;
  logic [15:0] p2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: pending request per dut/port and round-robin pointer.
  bit         pv [2][2];
  logic [7:0] pa [2][2];
  logic [7:0] pb [2][2];
  int         m_last [2];
  int         acc_cyc [2];

  function automatic logic [15:0] mul16(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] r;
    r = a * b;
    return r;
  endfunction

  mult_arbiter #(.DATA_WIDTH(8), .MULT_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0_valid(rq_v[0][0]), .req0_ready(rq_r[0][0]), .req0_a(rq_a[0][0]), .req0_b(rq_b[0][0]),
    .rsp0_valid(rs_v[0][0]), .rsp0_ready(rs_r[0][0]), .rsp0_data(rs_d[0][0]),
    .req1_valid(rq_v[0][1]), .req1_ready(rq_r[0][1]), .req1_a(rq_a[0][1]), .req1_b(rq_b[0][1]),
    .rsp1_valid(rs_v[0][1]), .rsp1_ready(rs_r[0][1]), .rsp1_data(rs_d[0][1]),
    .mul_in1(mi1[0]), .mul_in2(mi2[0]), .mul_out(mo0), .busy(bsy[0])
  );

  mult_arbiter #(.DATA_WIDTH(8), .MULT_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req0_valid(rq_v[1][0]), .req0_ready(rq_r[1][0]), .req0_a(rq_a[1][0]), .req0_b(rq_b[1][0]),
    .rsp0_valid(rs_v[1][0]), .rsp0_ready(rs_r[1][0]), .rsp0_data(rs_d[1][0]),
    .req1_valid(rq_v[1][1]), .req1_ready(rq_r[1][1]), .req1_a(rq_a[1][1]), .req1_b(rq_b[1][1]),
    .rsp1_valid(rs_v[1][1]), .rsp1_ready(rs_r[1][1]), .rsp1_data(rs_d[1][1]),
    .mul_in1(mi1[1]), .mul_in2(mi2[1]), .mul_out(mo1), .busy(bsy[1])
  );

  // Combinational multiplier for latency 1; combinational stage plus two
  // registers for latency 3 so the product is ready in the third stable cycle.
  assign mo0 = mul16(mi1[0], mi2[0]);
  always @(posedge clk) begin
    p1 <= mul16(mi1[1], mi2[1]);
    p2 <= p1;
  end
  assign mo1 = p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int d);
    for (int p = 0; p < 2; p++) begin
      rq_v[d][p] = pv[d][p];
      rq_a[d][p] = pa[d][p];
      rq_b[d][p] = pb[d][p];
    end
  endtask

  task automatic set_req(input int d, input int p, input logic [7:0] a, input logic [7:0] b);
    pv[d][p] = 1'b1;
    pa[d][p] = a;
    pb[d][p] = b;
  endtask

  task automatic chk_zero(input int d);
    chk("rst_busy", bsy[d], 0);
    chk("rst_mul_in1", mi1[d], 0);
    chk("rst_mul_in2", mi2[d], 0);
    for (int p = 0; p < 2; p++) begin
      chk("rst_req_ready", rq_r[d][p], 0);
      chk("rst_rsp_valid", rs_v[d][p], 0);
      chk("rst_rsp_data", rs_d[d][p], 0);
    end
  endtask

  // One full transaction: arbitration check in the entry cycle, accept, the
  // latency window, delay cycles of response backpressure, then the handshake.
  task automatic run_txn(input int d, input int delay, input bit raise);
    int g;
    int lat;
    logic [7:0] oa;
    logic [7:0] ob;
    logic [15:0] e;
    lat = (d == 1) ? 3 : 1;
    rs_r[d][0] = 1'b0;
    rs_r[d][1] = 1'b0;
    apply(d);
    #1;
    if (pv[d][0] && pv[d][1]) g = (m_last[d] == 1) ? 0 : 1;
    else if (pv[d][1]) g = 1;
    else g = 0;
    chk("idle_busy", bsy[d], 0);
    chk("req0_ready", rq_r[d][0], (pv[d][0] && g == 0) ? 1 : 0);
    chk("req1_ready", rq_r[d][1], (pv[d][1] && g == 1) ? 1 : 0);
    rs_r[d][1-g] = 1'($urandom_range(0, 1));
    step();
    acc_cyc[d] = cyc;
    m_last[d] = g;
    oa = pa[d][g];
    ob = pb[d][g];
    pv[d][g] = 1'b0;
    if (raise) set_req(d, 1 - g, 8'($urandom), 8'($urandom));
    apply(d);
    e = mul16(oa, ob);
    for (int k = 1; k <= lat; k++) begin
      #1;
      chk("wait_busy", bsy[d], 1);
      chk("wait_mul_in1", mi1[d], oa);
      chk("wait_mul_in2", mi2[d], ob);
      chk("wait_ready0", rq_r[d][0], 0);
      chk("wait_ready1", rq_r[d][1], 0);
      chk("wait_rsp0_valid", rs_v[d][0], 0);
      chk("wait_rsp1_valid", rs_v[d][1], 0);
      step();
    end
    for (int k = 0; k <= delay; k++) begin
      #1;
      chk("rsp_valid_owner", rs_v[d][g], 1);
      chk("rsp_data_owner", rs_d[d][g], e);
      chk("rsp_valid_other", rs_v[d][1-g], 0);
      chk("rsp_data_other", rs_d[d][1-g], 0);
      chk("rsp_busy", bsy[d], 1);
      chk("rsp_ready0", rq_r[d][0], 0);
      chk("rsp_ready1", rq_r[d][1], 0);
      if (k == delay) rs_r[d][g] = 1'b1;
      step();
    end
    rs_r[d][0] = 1'b0;
    rs_r[d][1] = 1'b0;
  endtask

  task automatic random_txns(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[d][p] && $urandom_range(0, 2) != 0) set_req(d, p, 8'($urandom), 8'($urandom));
      end
      if (!pv[d][0] && !pv[d][1]) set_req(d, int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      run_txn(d, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 2; i++) begin
      if (pv[d][0] || pv[d][1]) run_txn(d, 0, 1'b0);
    end
  endtask

  initial begin
    int first_acc;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1;
      acc_cyc[d] = 0;
      for (int p = 0; p < 2; p++) begin
        pv[d][p] = 1'b0;
        pa[d][p] = 8'h00;
        pb[d][p] = 8'h00;
        rs_r[d][p] = 1'b0;
      end
    end
    // Tie present from reset: req0 7x9, req1 -128x127.
    set_req(0, 0, 8'd7, 8'd9);
    set_req(0, 1, 8'h80, 8'd127);
    apply(0);
    apply(1);
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b1;

    run_txn(0, 0, 1'b0);
    run_txn(0, 0, 1'b0);

    // Repeated tie after both were served: req0 wins again.
    set_req(0, 0, 8'($urandom), 8'($urandom));
    set_req(0, 1, 8'($urandom), 8'($urandom));
    run_txn(0, 1, 1'b0);
    run_txn(0, 0, 1'b0);

    // Backpressure: req1 -128x-128 held for 5 cycles while req0 waits.
    set_req(0, 1, 8'h80, 8'h80);
    run_txn(0, 5, 1'b1);
    run_txn(0, 0, 1'b0);

    // Single request: -21 x 35.
    set_req(0, 0, 8'hEB, 8'd35);
    run_txn(0, 0, 1'b0);

    random_txns(0, 40);

    // Reset during WAIT.
    set_req(0, 0, 8'($urandom), 8'($urandom));
    apply(0);
    #1;
    chk("mid_accept_ready", rq_r[0][0], 1);
    step();
    pv[0][0] = 1'b0;
    apply(0);
    rq_v[0][1] = 1'b1;
    #1;
    chk("mid_busy", bsy[0], 1);
    rst = 1'b0;
    #1;
    chk_zero(0);
    step();
    rst = 1'b1;
    rq_v[0][1] = 1'b0;
    m_last[0] = 1;
    m_last[1] = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_rsp0", rs_v[0][0], 0);
      chk("post_rst_rsp1", rs_v[0][1], 0);
      chk("post_rst_busy", bsy[0], 0);
      step();
    end
    set_req(0, 0, 8'($urandom), 8'($urandom));
    set_req(0, 1, 8'($urandom), 8'($urandom));
    run_txn(0, 0, 1'b0);
    run_txn(0, 0, 1'b0);

    // Latency 3: single request, then back-to-back tie at the minimum interval.
    set_req(1, 0, 8'($urandom), 8'($urandom));
    run_txn(1, 0, 1'b0);
    set_req(1, 0, 8'($urandom), 8'($urandom));
    set_req(1, 1, 8'($urandom), 8'($urandom));
    run_txn(1, 0, 1'b0);
    first_acc = acc_cyc[1];
    run_txn(1, 0, 1'b0);
    chk("issue_interval", 32'(acc_cyc[1] - first_acc), 5);
    random_txns(1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
